hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Producer-side partner of the EX-stage forwarding logic. Reserves each issuing instruction's
//  destination register and releases it at writeback. Stalls ID when a source operand's producer
//  cannot yet be forwarded (load-use), and inserts a bubble into ID/EX on every stall cycle.
//  Sits between the ID stage and the ID/EX pipeline register; fed back from the WB stage.
// PARAMETERS
//  REG_ADDR_W  3  register-index width; NUM_REGS = 2**REG_ADDR_W; register 0 is hard-wired zero
//  LOAD_LAT    1  extra cycles before a load result is forwardable (1 = value forwardable from MEM/WB)
//  CNT_W       2  width of per-register outstanding-write counter (max 2**CNT_W-1 in flight)
// PORTS
//  clk           in   1           rising-edge clock
//  rst           in   1           synchronous, active-high reset
//  id_valid      in   1           ID holds a valid instruction
//  id_rs         in   REG_ADDR_W  source A index
//  id_rt         in   REG_ADDR_W  source B index
//  id_rs_used    in   1           instruction reads rs
//  id_rt_used    in   1           instruction reads rt
//  id_rd         in   REG_ADDR_W  destination index
//  id_reg_write  in   1           instruction writes rd
//  id_mem_read   in   1           instruction is a load
//  ex_flush      in   1           squash the instruction issued in the previous cycle
//  wb_reg_write  in   1           WB commits a register write this cycle
//  wb_rd         in   REG_ADDR_W  WB destination index
//  stall         out  1           hold PC and IF/ID (combinational)
//  id_issue      out  1           id_valid & ~stall (combinational)
//  ex_bubble     out  1           load NOP into ID/EX (registered)
//  sb_idle       out  1           no outstanding writes anywhere (combinational)
//  stall_cnt     out  16          saturating count of stall cycles (registered)
//  sb_overflow   out  1           sticky: reservation attempted on saturated counter (registered)
// BEHAVIOUR
//  State per reg r (r>=1): busy_cd[r] 2b countdown to forwardable; pend[r] CNT_W outstanding writes.
//  stall = id_valid & ((id_rs_used & id_rs!=0 & busy_cd[id_rs]!=0) | (id_rt_used & id_rt!=0 & busy_cd[id_rt]!=0)).
//  Issue (id_issue & id_reg_write & id_rd!=0): busy_cd[id_rd] <= id_mem_read ? LOAD_LAT : 0;
//   pend[id_rd] += 1; record last_rd/last_valid/last_pend_inc for flush.
//  Every cycle, all busy_cd != 0 decrement by 1, except an entry being set this cycle (set wins).
//  WB (wb_reg_write & wb_rd!=0): pend[wb_rd] -= 1; never below 0 (underflow ignored).
//  Same-cycle reserve and WB on same rd: net pend unchanged; busy_cd takes issue value.
//  ex_flush: if last_valid, pend[last_rd] -= 1 and busy_cd[last_rd] <= 0; last_valid cleared.
//   Flush coincident with new issue: flush applies to previous record, then new record is stored.
//  ex_bubble <= stall | ex_flush (1-cycle latency; NOP enters ID/EX the cycle after stall is seen).
//  stall_cnt increments on each stall cycle, holds at 16'hFFFF.
//  pend at max and new reservation: pend holds, sb_overflow <= 1 (cleared only by rst).
//  sb_idle = all pend == 0.
//  Reset (synchronous): all busy_cd=0, pend=0, last_valid=0, ex_bubble=0, stall_cnt=0,
//   sb_overflow=0; hence stall=0, sb_idle=1 the cycle after rst. rst dominates all same-cycle events;
//   reset mid-load discards the reservation with no later WB underflow fault.
//  Register 0 is never reserved, never stalls, never counted.
// STRUCTURE
//  Shared pipeline package: REG_ADDR_W, NUM_REGS, NOP encoding, LOAD_LAT default.
//  One sub-module: sb_entry (per-register busy_cd + pend with set/dec/flush/wb priority),
//   generated NUM_REGS-1 times; top holds stall decode, last-issue record, counters.
// TESTING
//  1 ALU r1<=.. then ALU reads r1 next cycle -> stall=0, sb_idle=0 until WB of r1, then 1.
//  2 load r2 then add reads r2 next cycle -> stall=1 one cycle, ex_bubble=1 following cycle, stall_cnt=1.
//  3 load r3, independent instr, then reader of r3 -> no stall (countdown expired).
//  4 load r4 then ex_flush next cycle; reader of r4 -> stall=0, pend[4]=0, sb_idle=1.
//  5 issue writer to r5 same cycle WB of older r5 -> pend[5] stays 1; four writers in flight -> sb_overflow=1.
//  6 rst asserted while load r6 pending -> next cycle stall=0, sb_idle=1, stall_cnt=0; late wb_rd=6 harmless.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline constants and types for the hazard scoreboard.
// Register-index width, register count, NOP encoding and load latency.
package hazard_scoreboard_pkg;
    localparam int REG_ADDR_W = 3;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;
    localparam int LOAD_LAT   = 1;
    localparam int CNT_W      = 2;
    localparam int CD_W       = 2;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/hazard_scoreboard_entry.sv
// One register's scoreboard state: forwarding countdown and outstanding writes.
// Issue beats flush on the countdown; pend moves by the net of reserve/wb/flush.
module sb_entry #(
    parameter int CNT_W = 2,
    parameter int CD_W  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set,
    input  logic [CD_W-1:0] set_val,
    input  logic            wb_dec,
    input  logic            flush,
    input  logic            flush_dec,
    output logic            busy,
    output logic [CNT_W-1:0] pend,
    output logic            ovf
);
    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    logic [CD_W-1:0]  busy_cd;
    logic [CNT_W:0]   sum;
    logic [CNT_W:0]   down;
    logic [CNT_W-1:0] pend_nxt;

    assign busy = |busy_cd;
    assign ovf  = set & (pend == PEND_MAX) & ~wb_dec & ~flush_dec;

    // Net outstanding-write count, saturating high and flooring at zero.
    always_comb begin
        sum  = (CNT_W+1)'(pend) + (CNT_W+1)'(set);
        down = (CNT_W+1)'(wb_dec) + (CNT_W+1)'(flush_dec);
        pend_nxt = pend;
        if (ovf)
            pend_nxt = pend;
        else if (sum < down)
            pend_nxt = '0;
        else
            pend_nxt = CNT_W'(sum - down);
    end

    // Countdown and pending-count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cd <= '0;
            pend    <= '0;
        end else begin
            pend <= pend_nxt;
            if (set)
                busy_cd <= set_val;
            else if (flush)
                busy_cd <= '0;
            else if (busy_cd != '0)
                busy_cd <= busy_cd - 1'b1;
        end
    end
endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard between ID and ID/EX, released from WB.
// Stalls ID on unforwardable producers and bubbles ID/EX on stall or flush.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W = hazard_scoreboard_pkg::REG_ADDR_W,
    parameter int LOAD_LAT   = hazard_scoreboard_pkg::LOAD_LAT,
    parameter int CNT_W      = hazard_scoreboard_pkg::CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  ex_flush,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  stall,
    output logic                  id_issue,
    output logic                  ex_bubble,
    output logic                  sb_idle,
    output logic [15:0]           stall_cnt,
    output logic                  sb_overflow
);
    localparam int NREG = 1 << REG_ADDR_W;

    logic [NREG-1:0]       busy;
    logic [NREG-1:0]       pend_nz;
    logic [NREG-1:0]       ovf;
    logic                  wr;
    logic                  last_valid;
    logic [REG_ADDR_W-1:0] last_rd;
    logic                  last_pend_inc;
    logic [CD_W-1:0]       set_val;

    assign busy[0]    = 1'b0;
    assign pend_nz[0] = 1'b0;
    assign ovf[0]     = 1'b0;

    assign set_val = id_mem_read ? CD_W'(LOAD_LAT) : '0;

    genvar r;
    generate
        for (r = 1; r < NREG; r++) begin : g_ent
            logic [CNT_W-1:0] pend;
            logic             hit_fl;
            assign hit_fl = ex_flush & last_valid
                          & (last_rd == REG_ADDR_W'(r));
            sb_entry #(.CNT_W(CNT_W), .CD_W(CD_W)) u_ent (
                .clk       (clk),
                .rst       (rst),
                .set       (wr & (id_rd == REG_ADDR_W'(r))),
                .set_val   (set_val),
                .wb_dec    (wb_reg_write & (wb_rd == REG_ADDR_W'(r))),
                .flush     (hit_fl),
                .flush_dec (hit_fl & last_pend_inc),
                .busy      (busy[r]),
                .pend      (pend),
                .ovf       (ovf[r])
            );
            assign pend_nz[r] = |pend;
        end
    endgenerate

    assign stall = id_valid
                 & ((id_rs_used & busy[id_rs])
                 |  (id_rt_used & busy[id_rt]));
    assign id_issue = id_valid & ~stall;
    assign wr       = id_issue & id_reg_write & (id_rd != '0);
    assign sb_idle  = ~|pend_nz;

    // Last-issue record, bubble, stall counter and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_valid    <= 1'b0;
            last_rd       <= '0;
            last_pend_inc <= 1'b0;
            ex_bubble     <= 1'b0;
            stall_cnt     <= '0;
            sb_overflow   <= 1'b0;
        end else begin
            ex_bubble  <= stall | ex_flush;
            last_valid <= wr;
            if (wr) begin
                last_rd       <= id_rd;
                last_pend_inc <= ~ovf[id_rd];
            end
            if (stall && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (|ovf)
                sb_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus
// randomized traffic against a cycle-timestamp reference model.
module tb_hazard_scoreboard;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [2:0] id_rs = '0;
    logic [2:0] id_rt = '0;
    logic       id_rs_used = 1'b0;
    logic       id_rt_used = 1'b0;
    logic [2:0] id_rd = '0;
    logic       id_reg_write = 1'b0;
    logic       id_mem_read = 1'b0;
    logic       ex_flush = 1'b0;
    logic       wb_reg_write = 1'b0;
    logic [2:0] wb_rd = '0;
    logic       stall;
    logic       id_issue;
    logic       ex_bubble;
    logic       sb_idle;
    logic [15:0] stall_cnt;
    logic       sb_overflow;

    int errors = 0;
    int checks = 0;

    // reference model: cycle at which each register becomes forwardable
    int m_cyc = 0;
    int m_fwd [8];
    int m_pend[8];
    bit m_lv;
    int m_lr;
    bit m_linc;
    int m_scnt;
    bit m_ovf;
    bit m_bub;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .ex_flush(ex_flush),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .stall(stall), .id_issue(id_issue),
        .ex_bubble(ex_bubble), .sb_idle(sb_idle),
        .stall_cnt(stall_cnt), .sb_overflow(sb_overflow)
    );

    always #5 clk = ~clk;

    function automatic bit m_stall();
        bit a, b;
        a = id_rs_used && id_rs != 0 && m_cyc < m_fwd[id_rs];
        b = id_rt_used && id_rt != 0 && m_cyc < m_fwd[id_rt];
        return id_valid && (a || b);
    endfunction

    function automatic bit m_idle();
        for (int r = 1; r < 8; r++)
            if (m_pend[r] != 0) return 1'b0;
        return 1'b1;
    endfunction

    // advance model with current inputs, then cross the clock edge
    task automatic tick();
        int delta[8];
        bit st, w, ninc;
        int n;
        if (rst) begin
            for (int r = 0; r < 8; r++) begin
                m_fwd[r] = 0;
                m_pend[r] = 0;
            end
            m_lv = 0; m_scnt = 0; m_ovf = 0; m_bub = 0;
        end else begin
            st = m_stall();
            w = id_valid && !st && id_reg_write && id_rd != 0;
            m_bub = st || ex_flush;
            if (st && m_scnt < 65535) m_scnt++;
            for (int r = 0; r < 8; r++) delta[r] = 0;
            if (ex_flush && m_lv) begin
                if (m_linc) delta[m_lr]--;
                m_fwd[m_lr] = m_cyc + 1;
            end
            if (wb_reg_write && wb_rd != 0) delta[wb_rd]--;
            if (w) delta[id_rd]++;
            ninc = 1;
            for (int r = 1; r < 8; r++) begin
                n = m_pend[r] + delta[r];
                if (n > 3) begin
                    n = 3;
                    m_ovf = 1;
                    if (w && r == int'(id_rd)) ninc = 0;
                end
                if (n < 0) n = 0;
                m_pend[r] = n;
            end
            if (w) m_fwd[id_rd] = m_cyc + 1 + (id_mem_read ? 1 : 0);
            m_lv = w;
            if (w) begin
                m_lr = id_rd;
                m_linc = ninc;
            end
        end
        m_cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(bit v, bit [2:0] rs, bit [2:0] rt, bit rsu,
                       bit rtu, bit [2:0] rd, bit rw, bit mr);
        id_valid = v; id_rs = rs; id_rt = rt;
        id_rs_used = rsu; id_rt_used = rtu;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        ex_flush = 0;
        wb_reg_write = 0;
        wb_rd = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        drv(1, 3, 5, 1, 1, 0, 0, 0);
        #1;
        checks++;
        if (stall !== 1'b0 || sb_idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_comb: stall=%b idle=%b want 0 1", stall, sb_idle);
        end
        checks++;
        if (ex_bubble !== 1'b0 || stall_cnt !== 16'd0 || sb_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: bub=%b cnt=%0d ovf=%b want 0 0 0",
                     ex_bubble, stall_cnt, sb_overflow);
        end
        idle();
    endtask

    task automatic test_alu_fwd();
        do_reset();
        drv(1, 0, 0, 0, 0, 1, 1, 0);
        tick();
        drv(1, 1, 1, 1, 1, 0, 0, 0);
        #1;
        checks++;
        if (stall !== 1'b0 || sb_idle !== 1'b0) begin
            errors++;
            $display("FAIL alu_fwd: stall=%b idle=%b want 0 0", stall, sb_idle);
        end
        tick();
        idle();
        wb_reg_write = 1; wb_rd = 1;
        tick();
        idle();
        #1;
        checks++;
        if (sb_idle !== 1'b1) begin
            errors++;
            $display("FAIL alu_wb_idle: idle=%b want 1", sb_idle);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drv(1, 0, 0, 0, 0, 2, 1, 1);
        tick();
        drv(1, 2, 0, 1, 0, 0, 0, 0);
        #1;
        checks++;
        if (stall !== 1'b1 || id_issue !== 1'b0) begin
            errors++;
            $display("FAIL load_use_stall: stall=%b issue=%b want 1 0", stall, id_issue);
        end
        tick();
        checks++;
        if (ex_bubble !== 1'b1 || stall_cnt !== 16'd1) begin
            errors++;
            $display("FAIL load_use_bubble: bub=%b cnt=%0d want 1 1", ex_bubble, stall_cnt);
        end
        checks++;
        if (stall !== 1'b0 || id_issue !== 1'b1) begin
            errors++;
            $display("FAIL load_use_release: stall=%b issue=%b want 0 1", stall, id_issue);
        end
        tick();
        checks++;
        if (ex_bubble !== 1'b0) begin
            errors++;
            $display("FAIL load_use_nobub: bub=%b want 0", ex_bubble);
        end
        idle();
    endtask

    task automatic test_load_gap();
        do_reset();
        drv(1, 0, 0, 0, 0, 3, 1, 1);
        tick();
        drv(1, 1, 2, 1, 1, 0, 0, 0);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL load_gap_indep: stall=%b want 0", stall);
        end
        tick();
        drv(1, 3, 3, 1, 1, 0, 0, 0);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL load_gap_reader: stall=%b want 0", stall);
        end
        tick();
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        drv(1, 0, 0, 0, 0, 4, 1, 1);
        tick();
        idle();
        ex_flush = 1;
        tick();
        ex_flush = 0;
        checks++;
        if (ex_bubble !== 1'b1) begin
            errors++;
            $display("FAIL flush_bubble: bub=%b want 1", ex_bubble);
        end
        drv(1, 0, 4, 0, 1, 0, 0, 0);
        #1;
        checks++;
        if (stall !== 1'b0 || sb_idle !== 1'b1) begin
            errors++;
            $display("FAIL flush_release: stall=%b idle=%b want 0 1", stall, sb_idle);
        end
        tick();
        idle();
    endtask

    task automatic test_overflow();
        do_reset();
        drv(1, 0, 0, 0, 0, 5, 1, 0);
        tick();
        wb_reg_write = 1; wb_rd = 5;
        tick();
        idle();
        wb_reg_write = 1; wb_rd = 5;
        #1;
        checks++;
        if (sb_idle !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_wb: idle=%b want 0", sb_idle);
        end
        tick();
        idle();
        #1;
        checks++;
        if (sb_idle !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_drain: idle=%b want 1", sb_idle);
        end
        for (int i = 0; i < 4; i++) begin
            drv(1, 0, 0, 0, 0, 5, 1, 0);
            tick();
            if (i == 2) begin
                checks++;
                if (sb_overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_early: ovf=%b want 0", sb_overflow);
                end
            end
        end
        checks++;
        if (sb_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: ovf=%b want 1", sb_overflow);
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            wb_reg_write = 1; wb_rd = 5;
            tick();
        end
        idle();
        #1;
        checks++;
        if (sb_idle !== 1'b1 || sb_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drain: idle=%b ovf=%b want 1 1", sb_idle, sb_overflow);
        end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        drv(1, 0, 0, 0, 0, 6, 1, 1);
        tick();
        drv(1, 6, 0, 1, 0, 0, 0, 0);
        rst = 1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: stall=%b want 1", stall);
        end
        tick();
        rst = 0;
        #1;
        checks++;
        if (stall !== 1'b0 || sb_idle !== 1'b1 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid_post: stall=%b idle=%b cnt=%0d want 0 1 0",
                     stall, sb_idle, stall_cnt);
        end
        idle();
        wb_reg_write = 1; wb_rd = 6;
        tick();
        idle();
        drv(1, 0, 0, 0, 0, 6, 1, 0);
        tick();
        idle();
        #1;
        checks++;
        if (sb_idle !== 1'b0 || sb_overflow !== 1'b0) begin
            errors++;
            $display("FAIL rst_late_wb: idle=%b ovf=%b want 0 0", sb_idle, sb_overflow);
        end
        wb_reg_write = 1; wb_rd = 6;
        tick();
        idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            drv($urandom_range(0, 3) != 0,
                3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                $urandom_range(0, 1) == 1);
            ex_flush = ($urandom_range(0, 7) == 0);
            wb_reg_write = ($urandom_range(0, 2) == 0);
            wb_rd = 3'($urandom_range(0, 7));
            #1;
            checks++;
            if (stall !== m_stall() || id_issue !== (id_valid && !m_stall())
                || sb_idle !== m_idle()) begin
                errors++;
                $display("FAIL rand_comb@%0d: stall=%b issue=%b idle=%b want %b %b %b",
                         i, stall, id_issue, sb_idle, m_stall(),
                         id_valid && !m_stall(), m_idle());
            end
            tick();
            checks++;
            if (ex_bubble !== m_bub || stall_cnt !== 16'(m_scnt)
                || sb_overflow !== m_ovf) begin
                errors++;
                $display("FAIL rand_regs@%0d: bub=%b cnt=%0d ovf=%b want %b %0d %b",
                         i, ex_bubble, stall_cnt, sb_overflow, m_bub, m_scnt, m_ovf);
            end
        end
        rst = 0;
        idle();
    endtask

    initial begin
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_load_gap();
        test_flush();
        test_overflow();
        test_reset_mid_load();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
